// File: rtl/conv_1_fm_writer_if.sv
// conv_1_fm_writer_if: bias BRAM read port, MAC result stream and dual-port feature-map BRAM write bus
// Ports (signals): bias_bram_en/addr/dout, mac_vld/data/rdy, fm_bram_en{a,b}/we{a,b}/addr{a,b}/din{a,b}
// master = the writer, slave = MAC source plus BRAMs
interface conv_1_fm_writer_if #(
   parameter int ACC_W  = 32,
   parameter int DATA_W = 16
);
   logic                bias_bram_en;
   logic [6:0]          bias_bram_addr;
   logic [2*DATA_W-1:0] bias_bram_dout;
   logic                mac_vld;
   logic [ACC_W-1:0]    mac_data;
   logic                mac_rdy;
   logic                fm_bram_ena, fm_bram_enb, fm_bram_wea, fm_bram_web;
   logic [6:0]          fm_bram_addra, fm_bram_addrb;
   logic [DATA_W-1:0]   fm_bram_dina, fm_bram_dinb;
   modport master (
      output bias_bram_en, bias_bram_addr, mac_rdy,
      output fm_bram_ena, fm_bram_enb, fm_bram_wea, fm_bram_web,
      output fm_bram_addra, fm_bram_addrb, fm_bram_dina, fm_bram_dinb,
      input  bias_bram_dout, mac_vld, mac_data
   );
   modport slave (
      input  bias_bram_en, bias_bram_addr, mac_rdy,
      input  fm_bram_ena, fm_bram_enb, fm_bram_wea, fm_bram_web,
      input  fm_bram_addra, fm_bram_addrb, fm_bram_dina, fm_bram_dinb,
      output bias_bram_dout, mac_vld, mac_data
   );
endinterface

// File: rtl/conv_1_fm_writer.sv
// conv_1_fm_writer: adds per-layer bias to conv_1 MAC results, saturates, writes even/odd pairs to the feature-map BRAM
// Ports: clk, rst (sync, active-high), wb_en (rising edge starts a run), bus (conv_1_fm_writer_if.master),
//        output_layer (current layer), busy, done (end-of-run pulse), drop_err (sticky dropped result)
// Build option: CONV_WB_RELU_EN clamps negative saturated results to zero
module conv_1_fm_writer #(
   parameter int ACC_W         = 32,
   parameter int DATA_W        = 16,
   parameter int OUT_PER_LAYER = 16,
   parameter int NUM_LAYERS    = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wb_en,
   conv_1_fm_writer_if.master bus,
   output logic [2:0]         output_layer,
   output logic               busy,
   output logic               done,
   output logic               drop_err
);
   typedef enum logic [2:0] {IDLE, BIAS_RD, BIAS_LAT, ACCEPT, NEXT} state_t;
   state_t state;
   logic wb_q, start, last_layer, wr;
   logic [6:0] cnt, base;
   logic [DATA_W-1:0] bias_r, hold_r, sat, res;
   logic [ACC_W:0] sum;
   assign start = wb_en & ~wb_q & ~busy;
   assign last_layer = output_layer == 3'(NUM_LAYERS - 1);
   assign base = 7'(output_layer) * 7'(OUT_PER_LAYER);
   assign bus.mac_rdy = state == ACCEPT;
   assign bus.bias_bram_addr = {5'd0, output_layer[2:1]};
   assign {bus.fm_bram_ena, bus.fm_bram_enb, bus.fm_bram_wea, bus.fm_bram_web} = {4{wr}};
   assign sum = {bus.mac_data[ACC_W-1], bus.mac_data} + {{(ACC_W + 1 - DATA_W){bias_r[DATA_W-1]}}, bias_r};
   // In range when every bit above the result's sign bit matches it; otherwise clamp toward the sum's sign
   assign sat = (&sum[ACC_W:DATA_W-1] | ~|sum[ACC_W:DATA_W-1]) ? sum[DATA_W-1:0]
                                                               : {sum[ACC_W], {(DATA_W - 1){~sum[ACC_W]}}};
`ifdef CONV_WB_RELU_EN
   assign res = sat[DATA_W-1] ? '0 : sat;
`else
   assign res = sat;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wb_q <= 1'b0;
         cnt <= '0;
         bias_r <= '0;
         hold_r <= '0;
         output_layer <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         drop_err <= 1'b0;
         wr <= 1'b0;
         bus.bias_bram_en <= 1'b0;
         bus.fm_bram_addra <= '0;
         bus.fm_bram_addrb <= '0;
         bus.fm_bram_dina <= '0;
         bus.fm_bram_dinb <= '0;
      end else begin
         wb_q <= wb_en;
         drop_err <= (drop_err & ~start) | (bus.mac_vld & ~bus.mac_rdy);
         wr <= 1'b0;
         done <= 1'b0;
         bus.bias_bram_en <= 1'b0;
         case (state)
            IDLE: if (start) begin
               output_layer <= '0;
               cnt <= '0;
               busy <= 1'b1;
               bus.bias_bram_en <= 1'b1;
               state <= BIAS_RD;
            end
            BIAS_RD: state <= BIAS_LAT;
            BIAS_LAT: begin
               bias_r <= output_layer[0] ? bus.bias_bram_dout[2*DATA_W-1:DATA_W] : bus.bias_bram_dout[DATA_W-1:0];
               state <= ACCEPT;
            end
            ACCEPT: if (bus.mac_vld) begin
               cnt <= cnt + 7'd1;
               if (!cnt[0]) hold_r <= res;
               else begin
                  wr <= 1'b1;
                  bus.fm_bram_addra <= base + {cnt[6:1], 1'b0};
                  bus.fm_bram_addrb <= base + cnt;
                  bus.fm_bram_dina <= hold_r;
                  bus.fm_bram_dinb <= res;
                  // The last pair's write cycle is the NEXT cycle; done shares it so busy covers done
                  if (cnt == 7'(OUT_PER_LAYER - 1)) begin
                     state <= NEXT;
                     done <= last_layer;
                  end
               end
            end
            NEXT: if (last_layer) begin
               busy <= 1'b0;
               state <= IDLE;
            end else begin
               output_layer <= output_layer + 3'd1;
               cnt <= '0;
               bus.bias_bram_en <= 1'b1;
               state <= BIAS_RD;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_1_fm_writer.sv
// tb_conv_1_fm_writer: directed runs of conv_1_fm_writer checked against a pair-write model and literal expectations
module tb_conv_1_fm_writer;
   logic clk = 1'b0, rst = 1'b1, wb_en = 1'b0;
   logic [2:0] output_layer;
   logic busy, done, drop_err;
   conv_1_fm_writer_if #(.ACC_W(32), .DATA_W(16)) bus ();
   conv_1_fm_writer dut (.clk(clk), .rst(rst), .wb_en(wb_en), .bus(bus),
                         .output_layer(output_layer), .busy(busy), .done(done), .drop_err(drop_err));
   always #5 clk = ~clk;
   logic [31:0] bias_mem [4];
   logic [15:0] fm [128];
   int checks = 0, errors = 0, run_id = 0, seen_run = 0, mcnt = 0, done_cnt = 0;
   logic pend = 1'b0, acc = 1'b0;
   logic [6:0] pa;
   logic [15:0] pha, phb, hold;
   always @(posedge clk) if (bus.bias_bram_en) bus.bias_bram_dout <= bias_mem[bus.bias_bram_addr[1:0]];
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   function automatic int bias_of(input int l);
      logic [31:0] w = bias_mem[l / 2];
      return (l % 2) ? int'($signed(w[31:16])) : int'($signed(w[15:0]));
   endfunction
   function automatic logic [15:0] ref_val(input logic [31:0] m, input int l);
      longint s = longint'($signed(m)) + longint'(bias_of(l));
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`ifdef CONV_WB_RELU_EN
      if (s < 0) s = 0;
`endif
      return 16'(s);
   endfunction
   function automatic logic [31:0] mac_val(input int run, input int l, input int i);
      case (l)
         0: return (run == 3) ? 32'd20 : 32'd10;
         1: return 32'(100 + i);
         2: return 32'(-50 * i);
         3: return 32'(i * 1000);
         4: return 32'(40000 - i * 10000);
         default: return (i == 0) ? 32'h0001_0000 : (i == 1) ? 32'hFFFF_0000 : 32'(3 * i - 20);
      endcase
   endfunction
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic mon();
      logic [15:0] v;
      if (run_id != seen_run) begin
         seen_run = run_id;
         mcnt = 0;
      end
      if (pend) begin
         chk("wr_strobe", {28'd0, bus.fm_bram_ena, bus.fm_bram_enb, bus.fm_bram_wea, bus.fm_bram_web}, 32'hF);
         chk("addra", {25'd0, bus.fm_bram_addra}, {25'd0, pa});
         chk("addrb", {25'd0, bus.fm_bram_addrb}, {25'd0, pa + 7'd1});
         chk("dina", {16'd0, bus.fm_bram_dina}, {16'd0, pha});
         chk("dinb", {16'd0, bus.fm_bram_dinb}, {16'd0, phb});
      end else
         chk("no_strobe", {28'd0, bus.fm_bram_ena, bus.fm_bram_enb, bus.fm_bram_wea, bus.fm_bram_web}, 32'h0);
      if (bus.fm_bram_ena && bus.fm_bram_wea) fm[bus.fm_bram_addra] = bus.fm_bram_dina;
      if (bus.fm_bram_enb && bus.fm_bram_web) fm[bus.fm_bram_addrb] = bus.fm_bram_dinb;
      if (bus.bias_bram_en) chk("bias_addr", {25'd0, bus.bias_bram_addr}, 32'((mcnt / 16) / 2));
      if (done) done_cnt++;
      pend = 1'b0;
      if (acc && !rst) begin
         chk("mac_rdy_on_accept", {31'd0, bus.mac_rdy}, 32'd1);
         v = ref_val(bus.mac_data, mcnt / 16);
         if (mcnt % 2 == 0) hold = v;
         else begin
            pend = 1'b1;
            pa = 7'(mcnt - 1);
            pha = hold;
            phb = v;
         end
         mcnt++;
      end
   endtask
   task automatic send(input logic [31:0] v);
      int w = 0;
      while (bus.mac_rdy !== 1'b1 && w < 64) begin
         cyc();
         w++;
      end
      if (w >= 64) begin
         checks++;
         errors++;
         $display("FAIL mac_rdy_timeout: got mac_rdy=%b required 1 within 64 cycles", bus.mac_rdy);
      end
      bus.mac_vld = 1'b1;
      bus.mac_data = v;
      acc = 1'b1;
      cyc();
      bus.mac_vld = 1'b0;
      acc = 1'b0;
   endtask
   task automatic feed(input int run, input int n);
      for (int k = 0; k < n; k++) begin
         if (run == 1 && k == 24) begin
            wb_en = 1'b0;
            cyc();
            wb_en = 1'b1;
            cyc();
         end
         send(mac_val(run, k / 16, k % 16));
      end
   endtask
   task automatic start_run();
      wb_en = 1'b1;
      run_id++;
      done_cnt = 0;
      cyc();
   endtask
   task automatic wait_idle();
      int w = 0;
      while (busy !== 1'b0 && w < 64) begin
         cyc();
         w++;
      end
      if (w >= 64) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: got busy=%b required 0 within 64 cycles", busy);
      end
   endtask
   task automatic chk_reset(input string n);
      chk({n, "_busy_done_drop"}, {29'd0, busy, done, drop_err}, 32'd0);
      chk({n, "_layer"}, {29'd0, output_layer}, 32'd0);
      chk({n, "_rdy_bias_en"}, {30'd0, bus.mac_rdy, bus.bias_bram_en}, 32'd0);
      chk({n, "_bias_addr"}, {25'd0, bus.bias_bram_addr}, 32'd0);
      chk({n, "_strobes"}, {28'd0, bus.fm_bram_ena, bus.fm_bram_enb, bus.fm_bram_wea, bus.fm_bram_web}, 32'd0);
      chk({n, "_addr"}, {18'd0, bus.fm_bram_addra, bus.fm_bram_addrb}, 32'd0);
      chk({n, "_din"}, {bus.fm_bram_dina, bus.fm_bram_dinb}, 32'd0);
   endtask
   initial begin
      bias_mem[0] = 32'h0003_0005;
      bias_mem[1] = 32'h0002_FFFE;
      bias_mem[2] = 32'h7FFF_0004;
      bias_mem[3] = 32'h0;
      bus.mac_vld = 1'b0;
      bus.mac_data = '0;
      cyc();
      cyc();
      @(negedge clk);
      chk_reset("reset");
      fork
         forever begin
            @(negedge clk);
            mon();
         end
      join_none
      cyc();
      rst = 1'b0;
      cyc();
      start_run();
      bus.mac_vld = 1'b1;
      bus.mac_data = 32'hDEAD;
      cyc();
      bus.mac_vld = 1'b0;
      @(negedge clk);
      chk("drop_err_set", {31'd0, drop_err}, 32'd1);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      feed(1, 96);
      wait_idle();
      chk("run1_done_pulses", 32'(done_cnt), 32'd1);
      chk("run1_final_layer", {29'd0, output_layer}, 32'd5);
      chk("fm0_l0", {16'd0, fm[0]}, 32'd15);
      chk("fm15_l0", {16'd0, fm[15]}, 32'd15);
      chk("fm16_l1_upper_bias", {16'd0, fm[16]}, 32'd103);
      chk("fm17_l1", {16'd0, fm[17]}, 32'd104);
`ifdef CONV_WB_RELU_EN
      chk("fm33_l2_neg", {16'd0, fm[33]}, 32'h0000);
      chk("fm81_sat_neg", {16'd0, fm[81]}, 32'h0000);
      chk("fm79_sat_neg", {16'd0, fm[79]}, 32'h0000);
`else
      chk("fm33_l2_neg", {16'd0, fm[33]}, 32'hFFCC);
      chk("fm81_sat_neg", {16'd0, fm[81]}, 32'h8000);
      chk("fm79_sat_neg", {16'd0, fm[79]}, 32'h8000);
`endif
      chk("fm64_sat_pos", {16'd0, fm[64]}, 32'h7FFF);
      chk("fm80_sat_pos", {16'd0, fm[80]}, 32'h7FFF);
      chk("fm95_sat_pos", {16'd0, fm[95]}, 32'h7FFF);
      repeat (5) cyc();
      chk("layer_holds", {29'd0, output_layer}, 32'd5);
      chk("single_done", 32'(done_cnt), 32'd1);
      chk("drop_err_sticky", {31'd0, drop_err}, 32'd1);
      wb_en = 1'b0;
      cyc();
      cyc();
      start_run();
      @(negedge clk);
      chk("drop_err_cleared", {31'd0, drop_err}, 32'd0);
      feed(2, 35);
      rst = 1'b1;
      wb_en = 1'b0;
      cyc();
      @(negedge clk);
      chk_reset("midrun_reset");
      cyc();
      rst = 1'b0;
      cyc();
      start_run();
      @(negedge clk);
      chk("restart_bias_en", {31'd0, bus.bias_bram_en}, 32'd1);
      chk("restart_layer", {29'd0, output_layer}, 32'd0);
      feed(3, 96);
      wait_idle();
      chk("run3_fm0", {16'd0, fm[0]}, 32'd25);
      chk("run3_fm1", {16'd0, fm[1]}, 32'd25);
      chk("run3_done_pulses", 32'(done_cnt), 32'd1);
      chk("run3_final_layer", {29'd0, output_layer}, 32'd5);
      repeat (3) cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
